// File: rtl/correlation_accum_cell.sv
// correlation_accum_cell
// Windowed correlation accumulator for template matching. Each valid beat
// multiplies pixel I against NUM_TEMPLATES template pixels and accumulates
// sum(I^2), sum(T[k]*I) and, optionally, sum(I) over WINDOW_LEN beats. The
// completed sums are presented with a one-cycle out_valid strobe two cycles
// after the last beat of a window. I is forwarded to the next cell with a
// one-cycle delay.
//
// Build option: define CORR_SUM_I_EN to build the sum(I) accumulator. When the
// macro is undefined, sum_I is tied to zero and no sum(I) logic exists.
`timescale 1ns/1ps

module correlation_accum_cell #(
  parameter  int PIXEL_SIZE    = 8,
  parameter  int NUM_TEMPLATES = 10,
  parameter  int WINDOW_LEN    = 16,
  localparam int ACC_W         = 2*PIXEL_SIZE + $clog2(WINDOW_LEN)
) (
  input  logic                                     CLK,
  input  logic                                     RST_N,
  input  logic                                     clear,
  input  logic                                     in_valid,
  input  logic [PIXEL_SIZE-1:0]                    I,
  input  logic [NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] T,
  output logic [PIXEL_SIZE-1:0]                    I_out,
  output logic                                     I_valid_out,
  output logic [ACC_W-1:0]                         sum_I,
  output logic [ACC_W-1:0]                         sum_I_square,
  output logic [NUM_TEMPLATES-1:0][ACC_W-1:0]      sum_T_x_I,
  output logic                                     out_valid
);

  localparam int PROD_W = 2*PIXEL_SIZE;
  localparam int PAD_W  = ACC_W - PROD_W;
  localparam int CNT_W  = $clog2(WINDOW_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW_LEN - 1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // A beat is accepted only when clear does not drop it.
  logic beat;
  assign beat = in_valid && !clear;

  // Pixel widened to product width so the multiplies are full precision.
  logic [PROD_W-1:0] i_wide;
  assign i_wide = {{PIXEL_SIZE{1'b0}}, I};

  // Stage-1 registers
  logic                                p_valid;
  logic                                p_first;
  logic                                p_last;
  logic [PROD_W-1:0]                   p_sq;
  logic [NUM_TEMPLATES-1:0][PROD_W-1:0] p_txi;

  // Stage-2 registers
  logic                                acc_last;
  logic [ACC_W-1:0]                    acc_sq;
  logic [NUM_TEMPLATES-1:0][ACC_W-1:0] acc_txi;

  // Beat counter and window FSM; clear aborts the open window.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values, which keeps the pipeline stages aligned.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      count <= '0;
    end else if (clear) begin
      state <= IDLE;
      count <= '0;
    end else if (in_valid) begin
      state <= ACCUM;
      count <= (count == LAST_BEAT) ? '0 : count + 1'b1;
    end else if (state == ACCUM && count == '0) begin
      // Window just completed and no new beat followed.
      state <= IDLE;
    end
  end

  // Stage 1: form the squared pixel and per-template products.
  // NOTE: datapath registers are reset too, so every output is zero after
  // reset without depending on the valid qualifiers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_sq    <= '0;
      p_txi   <= '0;
    end else begin
      p_valid <= beat;
      if (beat) begin
        p_first <= (count == '0);
        p_last  <= (count == LAST_BEAT);
        p_sq    <= i_wide * i_wide;
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
          p_txi[k] <= {{PIXEL_SIZE{1'b0}}, T[k]} * i_wide;
        end
      end
    end
  end

  // Stage 2: accumulate; the first beat of a window loads instead of adding.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_last <= 1'b0;
      acc_sq   <= '0;
      acc_txi  <= '0;
    end else if (clear) begin
      acc_last <= 1'b0;
      acc_sq   <= '0;
      acc_txi  <= '0;
    end else begin
      acc_last <= p_valid && p_last;
      if (p_valid) begin
        acc_sq <= p_first ? {{PAD_W{1'b0}}, p_sq}
                          : acc_sq + {{PAD_W{1'b0}}, p_sq};
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
          acc_txi[k] <= p_first ? {{PAD_W{1'b0}}, p_txi[k]}
                                : acc_txi[k] + {{PAD_W{1'b0}}, p_txi[k]};
        end
      end
    end
  end

  // Result registers: capture completed sums and pulse out_valid once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid    <= 1'b0;
      sum_I_square <= '0;
      sum_T_x_I    <= '0;
    end else begin
      out_valid <= acc_last;
      if (acc_last) begin
        sum_I_square <= acc_sq;
        sum_T_x_I    <= acc_txi;
      end
    end
  end

`ifdef CORR_SUM_I_EN
  logic [PIXEL_SIZE-1:0] p_i;
  logic [ACC_W-1:0]      acc_i;

  // Optional sum(I) path, aligned with the product pipeline above.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_i   <= '0;
      acc_i <= '0;
      sum_I <= '0;
    end else begin
      if (beat) begin
        p_i <= I;
      end
      if (clear) begin
        acc_i <= '0;
      end else if (p_valid) begin
        acc_i <= p_first ? {{(ACC_W-PIXEL_SIZE){1'b0}}, p_i}
                         : acc_i + {{(ACC_W-PIXEL_SIZE){1'b0}}, p_i};
      end
      if (acc_last) begin
        sum_I <= acc_i;
      end
    end
  end
`else
  assign sum_I = '0;
`endif

  // Chain forwarding of the pixel stream, independent of clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      I_out       <= '0;
      I_valid_out <= 1'b0;
    end else begin
      I_out       <= I;
      I_valid_out <= in_valid;
    end
  end

endmodule

// File: tb/tb_correlation_accum_cell.sv
// Testbench for correlation_accum_cell: a WINDOW_LEN=4 instance carries the
// table-driven windows and multi-cycle sequences; a WINDOW_LEN=16 instance
// covers the full-scale 16-beat window. Both share the same stimulus.
`timescale 1ns/1ps

module tb_correlation_accum_cell;

  localparam int PS     = 8;
  localparam int NT     = 10;
  localparam int ACC4_W = 2*PS + 2;
  localparam int ACC16_W = 2*PS + 4;

  logic                   CLK;
  logic                   RST_N;
  logic                   clear;
  logic                   in_valid;
  logic [PS-1:0]          I;
  logic [NT-1:0][PS-1:0]  T;

  logic [PS-1:0]              I_out4, I_out16;
  logic                       I_valid_out4, I_valid_out16;
  logic [ACC4_W-1:0]          sum_I4, sum_sq4;
  logic [NT-1:0][ACC4_W-1:0]  sum_txi4;
  logic                       out_valid4;
  logic [ACC16_W-1:0]         sum_I16, sum_sq16;
  logic [NT-1:0][ACC16_W-1:0] sum_txi16;
  logic                       out_valid16;

  correlation_accum_cell #(.PIXEL_SIZE(PS), .NUM_TEMPLATES(NT), .WINDOW_LEN(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .clear(clear), .in_valid(in_valid), .I(I), .T(T),
    .I_out(I_out4), .I_valid_out(I_valid_out4), .sum_I(sum_I4),
    .sum_I_square(sum_sq4), .sum_T_x_I(sum_txi4), .out_valid(out_valid4)
  );

  correlation_accum_cell #(.PIXEL_SIZE(PS), .NUM_TEMPLATES(NT), .WINDOW_LEN(16)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .clear(clear), .in_valid(in_valid), .I(I), .T(T),
    .I_out(I_out16), .I_valid_out(I_valid_out16), .sum_I(sum_I16),
    .sum_I_square(sum_sq16), .sum_T_x_I(sum_txi16), .out_valid(out_valid16)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected sum_I depends on whether the optional accumulator is built.
  function automatic longint exp_si(input longint v);
`ifdef CORR_SUM_I_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle's inputs at the falling edge; outputs are also read there.
  task automatic step(input logic iv, input logic [PS-1:0] v, input logic clr);
    @(negedge CLK);
    in_valid = iv;
    I        = v;
    clear    = clr;
  endtask

  task automatic set_t_ramp();
    for (int k = 0; k < NT; k++) T[k] = PS'(k + 1);
  endtask

  task automatic set_t_all(input logic [PS-1:0] v);
    for (int k = 0; k < NT; k++) T[k] = v;
  endtask

  // Strobe check on the 4-beat instance; ramp selects T[k]=k+1 versus T[k]=1.
  task automatic check_strobe4(input string nm, input longint ei, input longint esq, input bit ramp);
    check($sformatf("%s out_valid", nm), out_valid4, 1);
    check($sformatf("%s sum_I", nm), sum_I4, exp_si(ei));
    check($sformatf("%s sum_I_square", nm), sum_sq4, esq);
    for (int k = 0; k < NT; k++)
      check($sformatf("%s sum_T_x_I[%0d]", nm, k), sum_txi4[k], ramp ? (k + 1) * ei : ei);
  endtask

  typedef struct {
    logic [PS-1:0] px[4];
    int            gap_after;
    int            gap_len;
    longint        exp_i;
    longint        exp_sq;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Four-beat windows, T[k]=k+1, so sum_T_x_I[k] = (k+1) * sum(I).
    vecs[0] = '{px: '{8'd1, 8'd2, 8'd3, 8'd4},         gap_after: -1, gap_len: 0, exp_i: 10,   exp_sq: 30};
    vecs[1] = '{px: '{8'd1, 8'd2, 8'd3, 8'd4},         gap_after: 1,  gap_len: 3, exp_i: 10,   exp_sq: 30};
    vecs[2] = '{px: '{8'd5, 8'd6, 8'd7, 8'd8},         gap_after: -1, gap_len: 0, exp_i: 26,   exp_sq: 174};
    vecs[3] = '{px: '{8'd255, 8'd255, 8'd255, 8'd255}, gap_after: 2,  gap_len: 1, exp_i: 1020, exp_sq: 260100};
    vecs[4] = '{px: '{8'd0, 8'd0, 8'd0, 8'd0},         gap_after: -1, gap_len: 0, exp_i: 0,    exp_sq: 0};
    vecs[5] = '{px: '{8'd9, 8'd0, 8'd3, 8'd1},         gap_after: 0,  gap_len: 2, exp_i: 13,   exp_sq: 91};

    RST_N    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    I        = '0;
    set_t_ramp();

    // Reset state
    repeat (2) @(negedge CLK);
    check("reset out_valid", out_valid4, 0);
    check("reset sum_I", sum_I4, 0);
    check("reset sum_I_square", sum_sq4, 0);
    check("reset sum_T_x_I", sum_txi4, 0);
    check("reset I_out", I_out4, 0);
    check("reset I_valid_out", I_valid_out4, 0);
    check("reset out_valid16", out_valid16, 0);
    RST_N = 1'b1;

    // Table-driven windows, optionally with a mid-window gap
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < 4; b++) begin
        step(1'b1, vecs[v].px[b], 1'b0);
        if (b == vecs[v].gap_after) begin
          for (int g = 0; g < vecs[v].gap_len; g++) begin
            step(1'b0, 8'd0, 1'b0);
            check($sformatf("vec%0d gap out_valid", v), out_valid4, 0);
          end
        end
      end
      step(1'b0, 8'd0, 1'b0);
      check($sformatf("vec%0d +1 out_valid", v), out_valid4, 0);
      check($sformatf("vec%0d I_out", v), I_out4, vecs[v].px[3]);
      check($sformatf("vec%0d I_valid_out", v), I_valid_out4, 1);
      step(1'b0, 8'd0, 1'b0);
      check($sformatf("vec%0d +2 out_valid", v), out_valid4, 0);
      check($sformatf("vec%0d I_valid_out low", v), I_valid_out4, 0);
      step(1'b0, 8'd0, 1'b0);
      check_strobe4($sformatf("vec%0d", v), vecs[v].exp_i, vecs[v].exp_sq, 1'b1);
      step(1'b0, 8'd0, 1'b0);
      check($sformatf("vec%0d +4 out_valid", v), out_valid4, 0);
    end

    // Back-to-back windows 1..4 and 5..8: strobes at steps 7 and 11
    for (int s = 1; s <= 12; s++) begin
      step(s <= 8, (s <= 8) ? PS'(s) : 8'd0, 1'b0);
      if (s == 7)       check_strobe4("b2b win1", 10, 30, 1'b1);
      else if (s == 11) check_strobe4("b2b win2", 26, 174, 1'b1);
      else if (s >= 5)  check($sformatf("b2b step%0d out_valid", s), out_valid4, 0);
    end

    // Clear with a coincident beat 3, then four beats of I=2
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    step(1'b1, 8'd3, 1'b1);
    for (int s = 4; s <= 11; s++) begin
      step(s <= 7, (s <= 7) ? 8'd2 : 8'd0, 1'b0);
      if (s == 10) check_strobe4("after clear", 8, 16, 1'b1);
      else         check($sformatf("clear step%0d out_valid", s), out_valid4, 0);
    end

    // Clear one cycle after the last beat kills the in-flight window
    for (int s = 1; s <= 4; s++) step(1'b1, PS'(s), 1'b0);
    step(1'b0, 8'd0, 1'b1);
    for (int s = 6; s <= 9; s++) begin
      step(1'b0, 8'd0, 1'b0);
      check($sformatf("kill step%0d out_valid", s), out_valid4, 0);
    end
    check("kill holds sum_I_square", sum_sq4, 16);
    check("kill holds sum_I", sum_I4, exp_si(8));

    // Reset asserted during beat 2 clears everything at once
    set_t_all(8'd1);
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    check("midreset out_valid", out_valid4, 0);
    check("midreset sum_I", sum_I4, 0);
    check("midreset sum_I_square", sum_sq4, 0);
    check("midreset sum_T_x_I", sum_txi4, 0);
    check("midreset I_out", I_out4, 0);
    check("midreset I_valid_out", I_valid_out4, 0);
    step(1'b0, 8'd0, 1'b0);
    RST_N = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      step(s <= 4, (s <= 4) ? 8'd1 : 8'd0, 1'b0);
      if (s == 7)      check_strobe4("post reset", 4, 4, 1'b0);
      else if (s >= 5) check($sformatf("post reset step%0d out_valid", s), out_valid4, 0);
    end

    // Full-scale 16-beat window on the WINDOW_LEN=16 instance
    step(1'b0, 8'd0, 1'b1);
    set_t_all(8'd255);
    for (int s = 1; s <= 20; s++) begin
      step(s <= 16, (s <= 16) ? 8'd255 : 8'd0, 1'b0);
      if (s == 19) begin
        check("w16 out_valid", out_valid16, 1);
        check("w16 sum_I", sum_I16, exp_si(4080));
        check("w16 sum_I_square", sum_sq16, 1040400);
        for (int k = 0; k < NT; k++)
          check($sformatf("w16 sum_T_x_I[%0d]", k), sum_txi16[k], 1040400);
      end else if (s >= 2) begin
        check($sformatf("w16 step%0d out_valid", s), out_valid16, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/correlation_accum_cell.md
# correlation_accum_cell

Parametrised successor to the single-pixel correlation cell. It multiplies each incoming pixel `I` against `NUM_TEMPLATES` template pixels every valid beat. Instead of emitting raw per-pixel products, it accumulates ΣI², ΣT·I per template and (optionally) ΣI over a programmable window of `WINDOW_LEN` pixels, then presents the sums with a one-cycle `out_valid` strobe. It sits in the template-matching datapath between the pixel streamer and the normalisation/compare stage, and forwards `I` to the next cell in the chain.

## Interface
- `PIXEL_SIZE`, 8, pixel bit width (I and T, unsigned)
- `NUM_TEMPLATES`, 10, number of parallel templates
- `WINDOW_LEN`, 16, beats per accumulation window, ≥2
- `ACC_W`, 2*PIXEL_SIZE+$clog2(WINDOW_LEN), accumulator width (derived, not overridden)
- `CLK` in 1: clock, rising edge
- `RST_N` in 1: asynchronous active-low reset
- `clear` in 1: synchronous flush of window and pipeline
- `in_valid` in 1: `I`/`T` valid this cycle
- `I` in PIXEL_SIZE: image pixel
- `T` in PIXEL_SIZE × [NUM_TEMPLATES]: template pixels
- `I_out` out PIXEL_SIZE: `I` delayed one cycle (chain forwarding)
- `I_valid_out` out 1: `in_valid` delayed one cycle
- `sum_I` out ACC_W: ΣI of completed window
- `sum_I_square` out ACC_W: ΣI² of completed window
- `sum_T_x_I` out ACC_W × [NUM_TEMPLATES]: ΣT·I per template
- `out_valid` out 1: one-cycle strobe, sums valid

## Operation
- Stage 1, product: on `in_valid`, register I², T[k]·I (2*PIXEL_SIZE bits, unsigned), I zero-extended, `p_valid`, and `p_last` (beat index == WINDOW_LEN-1).
- Stage 2, accumulate: on `p_valid`, if `p_first`, accumulators load the products; otherwise they add them. On `p_valid && p_last`, the result registers capture the final sums and `out_valid` pulses.
- Beat counter 0..WINDOW_LEN-1 advances only on `in_valid`, wraps to 0 after the last beat.
- FSM: IDLE (count 0, no window open) → ACCUM on first `in_valid`; ACCUM → IDLE after the last beat if `in_valid` is low next cycle, else it stays ACCUM (new window).
- Back-to-back windows have no bubble: the first beat of the next window loads rather than adds.
- `in_valid` low: counter, accumulators and FSM hold. Gaps of any length are allowed mid-window.
- Result registers hold their value until the next window completes.
- Widths: ACC_W is exact for WINDOW_LEN beats of max value, so overflow is impossible and no saturation is applied.
- `clear` takes priority over `in_valid`. The coincident beat is dropped, the counter goes to 0, FSM to IDLE, accumulators to 0, and in-flight stage-1 valid is killed (no `out_valid` from it). Result registers are not cleared.
- `I_out`/`I_valid_out` forward regardless of `clear`.

## Timing
- Reset values (RST_N low, async): all outputs 0, counter 0, FSM IDLE, pipeline valids 0.
- Latency: the last beat is sampled at edge N, and `out_valid` plus sums are visible in the cycle after edge N+2, i.e. 2 cycles.
- `out_valid` is high for exactly one cycle per window. Consecutive windows at full rate give a strobe every WINDOW_LEN cycles.
- `I_out`/`I_valid_out` latency: 1 cycle.
- Reset asserted mid-window: everything is lost immediately. The window restarts at the first beat after release.

## Configuration
- `CORR_SUM_I_EN` defined: the ΣI accumulator and result register are built, and `sum_I` is live.
- Not defined: no ΣI logic is built and `sum_I` is tied to 0. All other behaviour and latency are unchanged.

## Test plan
- WINDOW_LEN=4, I=1,2,3,4 on consecutive cycles, T[k]=k+1 → one `out_valid` two cycles after the last beat. Results: sum_I=10, sum_I_square=30, sum_T_x_I[k]=10·(k+1).
- WINDOW_LEN=16, I=255 and all T=255 for 16 beats → sum_I_square = sum_T_x_I[k] = 1040400 (no overflow), sum_I=4080.
- Same 4-beat data with `in_valid` low for 3 cycles between beats 2 and 3 → identical sums. `out_valid` fires 2 cycles after beat 4.
- 8 consecutive beats (1..8), WINDOW_LEN=4 → two strobes 4 cycles apart. sum_I=10, then 26 (no carry-over). sum_I_square=30, then 174.
- `clear` with `in_valid` during beat 3 of a window, then 4 beats of I=2 → no strobe for the aborted window. Next strobe gives sum_I=8, sum_I_square=16.
- RST_N low during beat 2 → all outputs 0 immediately. After release, 4 beats of I=1, T=1 → sums 4/4/4.
